// File: rtl/frame_mem_arbiter.sv
// rtl/frame_mem_arbiter.sv - frame memory arbiter: video scan reads interleaved with two round-robin writers
// Optional build macro FRAME_MEM_VBLANK_WRITE_EN: when defined, writes are granted only during vertical blanking.
module frame_mem_arbiter #(
   parameter int unsigned WIDTH  = 640,
   parameter int unsigned HEIGHT = 480,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 15
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic [9:0]        x,
   input  logic [8:0]        y,
   output logic [DATA_W-1:0] rd_data,
   input  logic              w0_req,
   input  logic              w1_req,
   input  logic [ADDR_W-1:0] w0_addr,
   input  logic [ADDR_W-1:0] w1_addr,
   input  logic [DATA_W-1:0] w0_data,
   input  logic [DATA_W-1:0] w1_data,
   output logic              w0_gnt,
   output logic              w1_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned LINE_WORDS = WIDTH / 4;
   localparam int unsigned MEM_WORDS  = (WIDTH / 4) * (HEIGHT / 4);

   logic              phase_q;
   logic              last_q;      // writer granted most recently
   logic              rd_v1_q, rd_a1_q;
   logic              rd_v2_q, rd_a2_q;
   logic [DATA_W-1:0] rd_data_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_we_q;
   logic              w0_gnt_q, w1_gnt_q;

   logic              active;
   logic              write_slot;
   logic              write_ok;
   logic              any_req;
   logic              sel;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              addr_ok;
   logic [ADDR_W-1:0] rd_addr;

   // Scan address (y/4)*LINE_WORDS + x/4 built from shifted partial products of the constant
   always_comb begin
      rd_addr = ADDR_W'(x >> 2);
      for (int b = 0; b < 32; b++) begin
         if (LINE_WORDS[b]) begin
            rd_addr = rd_addr + (ADDR_W'(y >> 2) << b);
         end
      end
   end

   // Slot classification and writer selection from the current x,y and requests
   always_comb begin
      active     = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
      write_slot = phase_q || !active;
`ifdef FRAME_MEM_VBLANK_WRITE_EN
      write_ok   = write_slot && (32'(y) >= HEIGHT);
`else
      write_ok   = write_slot;
`endif
      any_req    = w0_req || w1_req;
      sel        = (w0_req && w1_req) ? ~last_q : ~w0_req;
      sel_addr   = sel ? w1_addr : w0_addr;
      sel_data   = sel ? w1_data : w0_data;
      addr_ok    = 32'(sel_addr) < MEM_WORDS;
   end

   // Phase toggle, read pipeline, write arbitration and registered memory port
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         phase_q     <= 1'b0;
         last_q      <= 1'b1;
         rd_v1_q     <= 1'b0;
         rd_a1_q     <= 1'b0;
         rd_v2_q     <= 1'b0;
         rd_a2_q     <= 1'b0;
         rd_data_q   <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         w0_gnt_q    <= 1'b0;
         w1_gnt_q    <= 1'b0;
      end else begin
         phase_q  <= ~phase_q;
         // every phase-0 slot completes two edges later: RAM data when active, zero in blanking
         rd_v1_q  <= ~phase_q;
         rd_a1_q  <= active;
         rd_v2_q  <= rd_v1_q;
         rd_a2_q  <= rd_a1_q;
         if (rd_v2_q) begin
            rd_data_q <= rd_a2_q ? mem_rdata : '0;
         end
         w0_gnt_q <= 1'b0;
         w1_gnt_q <= 1'b0;
         mem_we_q <= 1'b0;
         if (!write_slot) begin
            mem_addr_q <= rd_addr;
         end else if (write_ok && any_req) begin
            w0_gnt_q <= ~sel;
            w1_gnt_q <= sel;
            last_q   <= sel;
            // out-of-range writes are acknowledged but never reach the RAM
            if (addr_ok) begin
               mem_addr_q  <= sel_addr;
               mem_wdata_q <= sel_data;
               mem_we_q    <= 1'b1;
            end
         end
      end
   end

   assign rd_data   = rd_data_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign w0_gnt    = w0_gnt_q;
   assign w1_gnt    = w1_gnt_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb/tb_frame_mem_arbiter.sv - directed self-checking bench for frame_mem_arbiter
module tb_frame_mem_arbiter;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [9:0]  x;
   logic [8:0]  y;
   logic [7:0]  rd_data;
   logic        w0_req, w1_req;
   logic [14:0] w0_addr, w1_addr;
   logic [7:0]  w0_data, w1_data;
   logic        w0_gnt, w1_gnt;
   logic [14:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   int checks = 0;
   int errors = 0;

   frame_mem_arbiter dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .x         (x),
      .y         (y),
      .rd_data   (rd_data),
      .w0_req    (w0_req),
      .w1_req    (w1_req),
      .w0_addr   (w0_addr),
      .w1_addr   (w1_addr),
      .w0_data   (w0_data),
      .w1_data   (w1_data),
      .w0_gnt    (w0_gnt),
      .w1_gnt    (w1_gnt),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   initial begin
      reset = 1'b1; x = 10'd0; y = 9'd0;
      w0_req = 1'b1; w1_req = 1'b0;
      w0_addr = 15'd5; w0_data = 8'h33;
      w1_addr = 15'd0; w1_data = 8'h00;
      mem_rdata = 8'h00;
      repeat (3) step();
      check_eq("rst_rd_data", rd_data, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_w0_gnt", w0_gnt, 0);
      check_eq("rst_w1_gnt", w1_gnt, 0);
      reset = 1'b0;

`ifdef FRAME_MEM_VBLANK_WRITE_EN
      begin
         logic got;
         y = 9'd100;
         for (int i = 0; i < 4; i++) begin
            step();
            check_eq("vb_active_no_gnt", w0_gnt, 0);
         end
         y = 9'd480;
         got = 1'b0;
         for (int i = 0; i < 2 && !got; i++) begin
            step();
            if (w0_gnt) got = 1'b1;
         end
         check_eq("vb_blank_gnt", got, 1);
         check_eq("vb_blank_we", mem_we, 1);
      end
`else
      // first read slot after release: scan read, then w0 in the write slot
      step();
      check_eq("rel_e1_gnt", w0_gnt, 0);
      check_eq("rel_e1_addr", mem_addr, 0);
      step();
      check_eq("rel_e2_w0_gnt", w0_gnt, 1);
      check_eq("rel_e2_we", mem_we, 1);
      check_eq("rel_e2_addr", mem_addr, 5);
      check_eq("rel_e2_wdata", mem_wdata, 8'h33);
      w0_req = 1'b0;

      // read address and two-edge latency at x=8,y=4
      x = 10'd8; y = 9'd4;
      step();
      check_eq("rd_addr", mem_addr, 162);
      check_eq("rd_we", mem_we, 0);
      check_eq("rd_prev_zero", rd_data, 0);
      mem_rdata = 8'h5A;
      step();
      check_eq("idle_we", mem_we, 0);
      check_eq("idle_addr_hold", mem_addr, 162);
      check_eq("rd_hold", rd_data, 0);
      step();
      check_eq("rd_data_5a", rd_data, 8'h5A);

      // out-of-range write is acknowledged but dropped
      w0_req = 1'b1; w0_addr = 15'd19200; w0_data = 8'h11;
      step();
      check_eq("oor_gnt", w0_gnt, 1);
      check_eq("oor_we", mem_we, 0);
      check_eq("oor_addr_hold", mem_addr, 162);
      w0_req = 1'b0;

      // mid-operation reset with both writers pending, then round-robin from reset
      w0_req = 1'b1; w0_addr = 15'd10; w0_data = 8'hAA;
      w1_req = 1'b1; w1_addr = 15'd20; w1_data = 8'hBB;
      reset = 1'b1;
      step();
      check_eq("rst2_w0_gnt", w0_gnt, 0);
      check_eq("rst2_w1_gnt", w1_gnt, 0);
      check_eq("rst2_rd_data", rd_data, 0);
      reset = 1'b0;
      step();
      check_eq("rr_read_gnt", w0_gnt | w1_gnt, 0);
      check_eq("rr_read_addr", mem_addr, 162);
      for (int k = 0; k < 5; k++) begin
         logic e0, e1;
         step();
         e0 = (k == 0) || (k == 4);
         e1 = (k == 2);
         check_eq("rr_w0_gnt", w0_gnt, e0);
         check_eq("rr_w1_gnt", w1_gnt, e1);
         check_eq("rr_we", mem_we, e0 | e1);
         if (e0) check_eq("rr_w0_addr", mem_addr, 10);
         if (e1) check_eq("rr_w1_data", mem_wdata, 8'hBB);
      end
      w0_req = 1'b0; w1_req = 1'b0;

      // horizontal blanking: every slot writes, blanking read forces zero
      x = 10'd700; y = 9'd10;
      w1_req = 1'b1; w1_addr = 15'd30; w1_data = 8'hCC;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("hb_w1_gnt", w1_gnt, 1);
         check_eq("hb_w0_gnt", w0_gnt, 0);
         check_eq("hb_we", mem_we, 1);
         check_eq("hb_addr", mem_addr, 30);
         check_eq("hb_rd_data", rd_data, (k == 2) ? 8'h00 : 8'h5A);
      end
      w1_req = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
